// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//   Byte-wide register file for the UART system control path. One address
//   port is shared by writes and registered reads. Entries 0-3 are exported
//   continuously as configuration outputs for the ALU, UART and clock divider.
//
// Parameters
//   WIDTH    data width of each entry
//   DEPTH    number of entries (4 <= DEPTH <= 2**ADDR)
//   ADDR     address width
//
// Ports
//   CLK      clock, rising edge
//   RST      asynchronous active-low reset
//   WrEn     write enable
//   RdEn     read enable
//   Address  entry index for the read or write
//   WrData   write data
//   RdData   registered read data (holds when no read is performed)
//   RdD      read-data-valid, high for each cycle that follows a read
//   REG0     entry 0 (ALU operand A)
//   REG1     entry 1 (ALU operand B)
//   REG2     entry 2 (UART cfg: [0] parity en, [1] parity type, [7:2] prescale)
//   REG3     entry 3 (clock-divider ratio)
//
// Build option
//   REGFILE_WR_FWD_EN  when defined, a cycle with both WrEn and RdEn performs
//                      the write and the read; since both use the same
//                      address, the read returns WrData (write-through).
//                      When undefined, the write wins and the read is dropped.
// ---------------------------------------------------------------------------
module reg_file #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int ADDR  = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             WrEn,
   input  logic             RdEn,
   input  logic [ADDR-1:0]  Address,
   input  logic [WIDTH-1:0] WrData,
   output logic [WIDTH-1:0] RdData,
   output logic             RdD,
   output logic [WIDTH-1:0] REG0,
   output logic [WIDTH-1:0] REG1,
   output logic [WIDTH-1:0] REG2,
   output logic [WIDTH-1:0] REG3
);

   // Reset defaults: parity enabled, even parity, prescale 32; divide by 32.
   localparam logic [WIDTH-1:0] RST_UART_CFG = WIDTH'(8'h81);
   localparam logic [WIDTH-1:0] RST_DIV_RATIO = WIDTH'(8'h20);

   // One extra bit so DEPTH == 2**ADDR compares correctly.
   localparam logic [ADDR:0] DEPTH_EXT = (ADDR+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic             addr_ok;
   logic [WIDTH-1:0] rd_word;

   assign addr_ok = ({1'b0, Address} < DEPTH_EXT);

   // Out-of-range reads return zero rather than an undefined entry.
   always_comb begin
      rd_word = '0;
      if (addr_ok) begin
         rd_word = mem[Address];
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         mem[2] <= RST_UART_CFG;
         mem[3] <= RST_DIV_RATIO;
         RdData <= '0;
         RdD    <= 1'b0;
      end else begin
         if (WrEn && addr_ok) begin
            mem[Address] <= WrData;
         end
`ifdef REGFILE_WR_FWD_EN
         if (RdEn) begin
            RdD <= 1'b1;
            if (WrEn) begin
               // Same address port, so the read always hits the entry being written.
               RdData <= addr_ok ? WrData : '0;
            end else begin
               RdData <= rd_word;
            end
         end else begin
            RdD <= 1'b0;
         end
`else
         if (RdEn && !WrEn) begin
            RdData <= rd_word;
            RdD    <= 1'b1;
         end else begin
            RdD    <= 1'b0;
         end
`endif
      end
   end

   assign REG0 = mem[0];
   assign REG1 = mem[1];
   assign REG2 = mem[2];
   assign REG3 = mem[3];

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
//   Directed bench for reg_file with hand-computed expected values.
//   Inputs change 1 time unit after a rising edge; outputs are sampled at
//   the same offset, after the edge that acted on them.
// ---------------------------------------------------------------------------
module tb_reg_file;

   logic       CLK = 1'b0;
   logic       RST;
   logic       WrEn;
   logic       RdEn;
   logic [3:0] Address;
   logic [7:0] WrData;
   logic [7:0] RdData;
   logic       RdD;
   logic [7:0] REG0, REG1, REG2, REG3;

   int n_checks = 0;
   int n_errors = 0;

   reg_file #(.WIDTH(8), .DEPTH(16), .ADDR(4)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .WrEn    (WrEn),
      .RdEn    (RdEn),
      .Address (Address),
      .WrData  (WrData),
      .RdData  (RdData),
      .RdD     (RdD),
      .REG0    (REG0),
      .REG1    (REG1),
      .REG2    (REG2),
      .REG3    (REG3)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_write(input logic [3:0] addr, input logic [7:0] data);
      WrEn    = 1'b1;
      RdEn    = 1'b0;
      Address = addr;
      WrData  = data;
      @(posedge CLK);
      #1;
      check("wr_rdd", 32'(RdD), 32'd0);
   endtask

   task automatic do_read(input logic [3:0] addr, input logic [7:0] exp);
      WrEn    = 1'b0;
      RdEn    = 1'b1;
      Address = addr;
      @(posedge CLK);
      #1;
      check("rd_rdd", 32'(RdD), 32'd1);
      check("rd_data", 32'(RdData), 32'(exp));
   endtask

   task automatic do_idle(input logic [7:0] held);
      WrEn = 1'b0;
      RdEn = 1'b0;
      @(posedge CLK);
      #1;
      check("idle_rdd", 32'(RdD), 32'd0);
      check("idle_hold", 32'(RdData), 32'(held));
   endtask

   initial begin
      RST     = 1'b0;
      WrEn    = 1'b0;
      RdEn    = 1'b0;
      Address = '0;
      WrData  = '0;
      #12;
      check("rst_rdd", 32'(RdD), 32'd0);
      check("rst_rddata", 32'(RdData), 32'd0);
      check("rst_reg0", 32'(REG0), 32'h00);
      check("rst_reg2", 32'(REG2), 32'h81);
      check("rst_reg3", 32'(REG3), 32'h20);
      RST = 1'b1;
      @(posedge CLK);
      #1;

      // Back-to-back reads with RdEn held high.
      do_read(4'd2, 8'h81);
      do_read(4'd3, 8'h20);
      do_read(4'd0, 8'h00);
      do_idle(8'h00);

      do_write(4'd0, 8'hAA);
      check("reg0_after_wr", 32'(REG0), 32'hAA);
      do_write(4'd1, 8'h55);
      do_write(4'd4, 8'hFF);
      do_read(4'd0, 8'hAA);
      do_read(4'd1, 8'h55);
      do_read(4'd4, 8'hFF);

      do_write(4'd2, 8'h12);
      do_write(4'd3, 8'h34);
      check("reg0", 32'(REG0), 32'hAA);
      check("reg1", 32'(REG1), 32'h55);
      check("reg2", 32'(REG2), 32'h12);
      check("reg3", 32'(REG3), 32'h34);
      do_read(4'd2, 8'h12);
      do_read(4'd3, 8'h34);
      do_idle(8'h34);

      // Last entry.
      do_write(4'd15, 8'hC3);
      do_read(4'd15, 8'hC3);

      // A write does not disturb the last read data.
      do_read(4'd4, 8'hFF);
      do_write(4'd4, 8'h0F);
      check("wr_hold", 32'(RdData), 32'hFF);

      // Simultaneous write and read at address 5.
      WrEn    = 1'b1;
      RdEn    = 1'b1;
      Address = 4'd5;
      WrData  = 8'h77;
      @(posedge CLK);
      #1;
`ifdef REGFILE_WR_FWD_EN
      check("both_rdd", 32'(RdD), 32'd1);
      check("both_data", 32'(RdData), 32'h77);
`else
      check("both_rdd", 32'(RdD), 32'd0);
      check("both_data", 32'(RdData), 32'hFF);
`endif
      do_read(4'd5, 8'h77);
      do_read(4'd4, 8'h0F);

      // Reset in the middle of a read stream.
      do_read(4'd0, 8'hAA);
      #2;
      RST = 1'b0;
      #1;
      check("mrst_rdd", 32'(RdD), 32'd0);
      check("mrst_rddata", 32'(RdData), 32'd0);
      check("mrst_reg0", 32'(REG0), 32'h00);
      check("mrst_reg1", 32'(REG1), 32'h00);
      check("mrst_reg2", 32'(REG2), 32'h81);
      check("mrst_reg3", 32'(REG3), 32'h20);
      #1;
      RST = 1'b1;
      @(posedge CLK);
      #1;
      // RdEn still high: first edge after release reads entry 0 again.
      check("post_rst_rdd", 32'(RdD), 32'd1);
      check("post_rst_data", 32'(RdData), 32'h00);
      do_read(4'd4, 8'h00);
      do_idle(8'h00);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
